// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - main control FSM for the multicycle CPU datapath
module multicycle_control #(
    parameter int                      OPCODE_WIDTH = 6,
    parameter logic [OPCODE_WIDTH-1:0] OP_RTYPE     = 'h00,
    parameter logic [OPCODE_WIDTH-1:0] OP_LW        = 'h23,
    parameter logic [OPCODE_WIDTH-1:0] OP_SW        = 'h2B,
    parameter logic [OPCODE_WIDTH-1:0] OP_BEQ       = 'h04,
    parameter logic [OPCODE_WIDTH-1:0] OP_J         = 'h02,
    parameter logic [OPCODE_WIDTH-1:0] OP_ADDI      = 'h08
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic                    mem_ready,
    output logic                    pc_write,
    output logic                    pc_write_cond,
    output logic                    i_or_d,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic                    ir_write,
    output logic                    mem_to_reg,
    output logic                    reg_dst,
    output logic                    reg_write,
    output logic                    alu_src_a,
    output logic [1:0]              alu_src_b,
    output logic [1:0]              alu_op,
    output logic [1:0]              pc_source,
    output logic                    illegal,
    output logic [3:0]              state_out
);

    localparam logic [3:0] S_RST     = 4'd0;
    localparam logic [3:0] S_FETCH   = 4'd1;
    localparam logic [3:0] S_DECODE  = 4'd2;
    localparam logic [3:0] S_MEMADR  = 4'd3;
    localparam logic [3:0] S_MEMRD   = 4'd4;
    localparam logic [3:0] S_MEMWB   = 4'd5;
    localparam logic [3:0] S_MEMWR   = 4'd6;
    localparam logic [3:0] S_EXEC    = 4'd7;
    localparam logic [3:0] S_RWB     = 4'd8;
    localparam logic [3:0] S_BRANCH  = 4'd9;
    localparam logic [3:0] S_JUMP    = 4'd10;
    localparam logic [3:0] S_ADDI_EX = 4'd11;
    localparam logic [3:0] S_ADDI_WB = 4'd12;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_4    = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_IMM2 = 2'b11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    logic [3:0] state;
    logic [3:0] state_nxt;
    logic       opcode_known;

    assign opcode_known = (opcode == OP_RTYPE) || (opcode == OP_LW)  ||
                          (opcode == OP_SW)    || (opcode == OP_BEQ) ||
                          (opcode == OP_J)     || (opcode == OP_ADDI);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_RST;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = S_FETCH;
        case (state)
            S_RST:     state_nxt = S_FETCH;
            S_FETCH:   state_nxt = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if ((opcode == OP_LW) || (opcode == OP_SW)) begin
                    state_nxt = S_MEMADR;
                end else if (opcode == OP_RTYPE) begin
                    state_nxt = S_EXEC;
                end else if (opcode == OP_BEQ) begin
                    state_nxt = S_BRANCH;
                end else if (opcode == OP_J) begin
                    state_nxt = S_JUMP;
                end else if (opcode == OP_ADDI) begin
                    state_nxt = S_ADDI_EX;
                end else begin
                    state_nxt = S_FETCH;
                end
            end
            S_MEMADR:  state_nxt = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_nxt = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:   state_nxt = S_FETCH;
            S_MEMWR:   state_nxt = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:    state_nxt = S_RWB;
            S_RWB:     state_nxt = S_FETCH;
            S_BRANCH:  state_nxt = S_FETCH;
            S_JUMP:    state_nxt = S_FETCH;
            S_ADDI_EX: state_nxt = S_ADDI_WB;
            S_ADDI_WB: state_nxt = S_FETCH;
            default:   state_nxt = S_FETCH;
        endcase
    end

    // Everything decodes from state alone, except the FETCH write enables which
    // must wait for the instruction word to actually arrive.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_B;
        alu_op        = ALU_ADD;
        pc_source     = PCS_ALU;
        illegal       = 1'b0;
        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_4;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM2;
                illegal   = !opcode_known;
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            S_RWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCS_ALUOUT;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCS_JUMP;
            end
            S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_ADDI_WB: begin
                reg_write = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign state_out = state;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multicycle CPU datapath.
- Sequences the write-enabled register bank (PC, IR, MDR, A, B, ALUOut) and the register file.
- Drives every mux select and ALU operation class, one instruction per 3–5+ states.
- Stalls on a memory-ready handshake. Flags illegal opcodes.

Parameters:
- OPCODE_WIDTH, 6, width of the instruction opcode field.
- OP_RTYPE, 6'h00, R-type opcode.
- OP_LW, 6'h23, load word.
- OP_SW, 6'h2B, store word.
- OP_BEQ, 6'h04, branch if equal.
- OP_J, 6'h02, jump.
- OP_ADDI, 6'h08, add immediate.

Ports:
- Clk, in, 1, rising-edge clock.
- Reset, in, 1, asynchronous, active-low reset.
- Opcode, in, OPCODE_WIDTH, IR[31:26], valid from DECODE onward.
- MemReady, in, 1, memory has completed the current read or write this cycle.
- PCWrite, out, 1, unconditional PC write enable.
- PCWriteCond, out, 1, PC write enable qualified by ALU Zero (external AND/OR).
- IorD, out, 1, memory address select: 0 = PC, 1 = ALUOut.
- MemRead, out, 1, memory read request.
- MemWrite, out, 1, memory write request.
- IRWrite, out, 1, IR write enable.
- MemtoReg, out, 1, register-file write data select: 0 = ALUOut, 1 = MDR.
- RegDst, out, 1, destination register select: 0 = rt, 1 = rd.
- RegWrite, out, 1, register-file write enable.
- ALUSrcA, out, 1, ALU A select: 0 = PC, 1 = A.
- ALUSrcB, out, 2, ALU B select: 00 = B, 01 = const 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- ALUOp, out, 2, ALU class: 00 = add, 01 = subtract, 10 = funct-decoded.
- PCSource, out, 2, PC source: 00 = ALU, 01 = ALUOut, 10 = jump target.
- Illegal, out, 1, one-cycle pulse in DECODE when the opcode is unsupported.
- StateOut, out, 4, current state encoding (debug and verification).

Behaviour:
- Registered state, 4 bits. Outputs are decoded combinationally from state; PCWrite/IRWrite in FETCH are also qualified by MemReady.
- Reset low (asynchronous): state = RST (0). All outputs are 0 in RST.
- First rising edge after Reset goes high: RST -> FETCH. No datapath write occurs in the RST cycle.
- States and assertions (any output not listed is 0):
  - FETCH(1): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite = PCWrite = MemReady. Stays in FETCH while !MemReady; MemReady -> DECODE.
  - DECODE(2): ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next state by Opcode:
    - LW/SW -> MEMADR
    - RTYPE -> EXEC
    - BEQ -> BRANCH
    - J -> JUMP
    - ADDI -> ADDI_EX
    - other -> FETCH with Illegal=1 for this cycle; no writes.
  - MEMADR(3): ALUSrcA=1, ALUSrcB=10, ALUOp=00. LW -> MEMRD; SW -> MEMWR.
  - MEMRD(4): MemRead=1, IorD=1. Held until MemReady, then -> MEMWB. MDR captures every cycle externally.
  - MEMWB(5): RegWrite=1, MemtoReg=1, RegDst=0 -> FETCH.
  - MEMWR(6): MemWrite=1, IorD=1. Held until MemReady, then -> FETCH.
  - EXEC(7): ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> RWB.
  - RWB(8): RegWrite=1, RegDst=1, MemtoReg=0 -> FETCH.
  - BRANCH(9): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01 -> FETCH.
  - JUMP(10): PCWrite=1, PCSource=10 -> FETCH.
  - ADDI_EX(11): ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> ADDI_WB.
  - ADDI_WB(12): RegWrite=1, RegDst=0, MemtoReg=0 -> FETCH.
- Unused encodings 13–15: all outputs 0, next state FETCH.
- Instruction latency with MemReady always high: J and BEQ 3 cycles; R-type, ADDI and SW 4 cycles; LW 5 cycles. Each memory wait cycle adds 1.
- Opcode is sampled only in DECODE and MEMADR; its value in other states is ignored.
- MemReady is ignored outside FETCH, MEMRD and MEMWR.
- Reset asserted mid-instruction: immediate return to RST, all outputs 0 in the same cycle. A held memory request is dropped.
- MemRead and MemWrite are never asserted together. RegWrite and MemWrite are never asserted together.

Test Plan:
- Reset release with MemReady=1, Opcode=6'h00 -> StateOut sequence 0,1,2,7,8,1. RegWrite=1 and RegDst=1 only in state 8. IRWrite=PCWrite=1 only in state 1.
- LW (6'h23) with MemReady low for 2 cycles in MEMRD -> states 1,2,3,4,4,4,5,1. MemRead=1 and IorD=1 on all three MEMRD cycles. MemtoReg=1 and RegWrite=1 in state 5.
- FETCH with MemReady=0 for 3 cycles -> state held at 1, MemRead=1, IRWrite=0 and PCWrite=0 until the MemReady cycle.
- BEQ (6'h04) then J (6'h02) -> states 9 and 10 each last 1 cycle. PCWriteCond=1 with PCSource=01 in state 9. PCWrite=1 with PCSource=10 in state 10.
- Opcode 6'h3F in DECODE -> Illegal pulses for 1 cycle, next state 1, no RegWrite, MemWrite or PCWrite in that cycle.
- SW (6'h2B) with Reset driven low during MEMWR while MemReady=0 -> StateOut=0 and MemWrite=0 asynchronously. After release, next state is 1.
